dd_arbiter: RTL and testbench
=============================

Name: dd_arbiter

Overview:
Round-robin arbiter that shares one binary-to-BCD converter (double_dabble) among NUM_REQ requesters, such as seven-segment front-ends and status displays. Each requester submits a binary value through a valid/ready handshake. The arbiter sequences the converter's start/done protocol and returns the BCD result with a per-requester response strobe. A watchdog reports a converter that never completes.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
INPUT_WIDTH, 32, binary operand width
DECIMAL_DIGITS, 8, BCD digits; result width = 4*DECIMAL_DIGITS
TIMEOUT_CYCLES, 1024, max BUSY cycles before error response; 0 disables the watchdog

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  request pending, one bit per requester
req_binary  in  NUM_REQ*INPUT_WIDTH  operands; requester i occupies slice [i*INPUT_WIDTH +: INPUT_WIDTH]
req_ready  out  NUM_REQ  one-cycle accept pulse; operand captured
resp_valid  out  NUM_REQ  one-cycle result strobe to the granted requester
resp_bcd  out  4*DECIMAL_DIGITS  shared result bus, valid only while some resp_valid bit is high
resp_err  out  1  high with resp_valid when the response is a timeout
dd_binary  out  INPUT_WIDTH  operand to converter
dd_start  out  1  one-cycle start pulse to converter
dd_bcd  in  4*DECIMAL_DIGITS  converter result
dd_done  in  1  converter completion
busy  out  1  high in BUSY
grant_id  out  clog2(NUM_REQ)  index of current/last granted requester

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE, rr_ptr=0, grant_id=0, req_ready=0, resp_valid=0, resp_err=0, resp_bcd=0, dd_binary=0, dd_start=0, busy=0, timeout counter=0.
  - Reset mid-conversion discards the in-flight result; no response is issued.
  - A dd_done arriving after reset is ignored.
- Defaults: req_ready, resp_valid, resp_err and dd_start are cleared every cycle unless set as described below.
- IDLE:
  - If any req_valid bit is set, g = first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - At that edge: req_ready[g]=1, dd_binary=req_binary slice g, dd_start=1, grant_id=g, counter=0, state->BUSY.
  - If no bit is set, stay in IDLE.
- BUSY (busy=1):
  - dd_done is ignored in the cycle dd_start is high.
  - On a later dd_done: resp_bcd=dd_bcd, resp_valid[grant_id]=1, resp_err=0, rr_ptr=(grant_id+1) mod NUM_REQ, state->IDLE.
  - Otherwise the counter increments. If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 without dd_done: resp_bcd=0, resp_valid[grant_id]=1, resp_err=1, rr_ptr advances, state->IDLE.
  - A dd_done coinciding with the timeout cycle wins; normal response.
- Handshake rules:
  - Requester holds req_valid and its operand stable until it sees req_ready.
  - It may drop req_valid or present a new operand in the cycle after req_ready.
  - req_valid is not sampled in BUSY.
  - A requester may deassert req_valid before it is granted; no grant results.
- Latency: grant edge E0; dd_start visible E0..E1. Response visible one cycle after the edge that samples dd_done. Next grant no earlier than the edge after the response edge, giving a minimum of 1 IDLE cycle between jobs.
- Fairness: after a grant to g, g has lowest priority. With all requesters valid, grants go 0,1,..,NUM_REQ-1, then repeat.
- Width: dd_bcd passes through unmodified. Values exceeding DECIMAL_DIGITS are the converter's concern.

Decomposition:
- Shared package holds: state encoding (ST_IDLE, ST_BUSY), the clog2 helper for the grant_id width, and the operand slice-index convention.
- One sub-module: dd_rr_pick. It is combinational and takes req_valid and rr_ptr, producing the grant index and an any_valid flag.
- double_dabble stays outside the arbiter and is wired through the dd_* ports, so the bench can model converter latency directly.

Test Plan:
- Single request: req 1 valid with 0x000004D2; converter model 34-cycle latency returning 0x00001234 -> req_ready[1] once; dd_binary=0x000004D2; resp_valid[1] once with resp_bcd=0x00001234; resp_err=0; busy high for 34+ cycles.
- All four requesters valid from reset with operands 1, 22, 333, 4444 -> grants in order 0,1,2,3; responses 0x00000001, 0x00000022, 0x00000333, 0x00004444, each routed to the correct resp_valid bit; exactly one req_ready per requester.
- Round-robin pointer check: after grant 1 completes, requesters 0 and 2 both valid -> 2 is granted before 0.
- Pass-through max value: operand 0x05F5E0FF -> resp_bcd=0x99999999; dd_done held high during the dd_start cycle does not cause an early response.
- Timeout: TIMEOUT_CYCLES=16, converter never asserts dd_done -> resp_valid[g] with resp_err=1 and resp_bcd=0 exactly 16 cycles after grant; the next pending requester is then granted normally.
- Reset mid-op: resetn low 1 cycle during BUSY, converter later pulses dd_done -> no resp_valid; all outputs at reset values; rr_ptr=0, so requester 0 wins the next contest.

Source files
------------

// File: rtl/dd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dd_arbiter_pkg
//  Description : Shared types and helpers for the double-dabble arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dd_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Minimum width of 1 so that single-value counters and indices stay legal.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        if (width == 0) begin
            width = 1;
        end
        return width;
    endfunction

    // Requester idx owns bits [idx*width +: width] of the flattened operand bus.
    function automatic int operand_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dd_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : dd_rr_pick
//  Description : Round-robin picker: first valid requester at or after rr_ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
module dd_rr_pick
    import dd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any_valid
);

    int w_idx;

    always_comb begin
        grant_idx = '0;
        any_valid = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!any_valid && req_valid[w_idx[PTR_W-1:0]]) begin
                any_valid = 1'b1;
                grant_idx = w_idx[PTR_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dd_arbiter
//  Description : Round-robin sharing of one binary-to-BCD converter among
//                NUM_REQ requesters, with a completion watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module dd_arbiter
    import dd_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int INPUT_WIDTH    = 32,
    parameter int DECIMAL_DIGITS = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_binary,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [4*DECIMAL_DIGITS-1:0]   resp_bcd,
    output logic                          resp_err,
    output logic [INPUT_WIDTH-1:0]        dd_binary,
    output logic                          dd_start,
    input  logic [4*DECIMAL_DIGITS-1:0]   dd_bcd,
    input  logic                          dd_done,
    output logic                          busy,
    output logic [clog2(NUM_REQ)-1:0]     grant_id
);

    localparam int c_ptr_w = clog2(NUM_REQ);
    localparam int c_bcd_w = 4 * DECIMAL_DIGITS;
    localparam int c_cnt_w = clog2(TIMEOUT_CYCLES + 1);
    localparam bit c_to_en = (TIMEOUT_CYCLES != 0);
    localparam logic [c_cnt_w-1:0] c_to_last =
        c_cnt_w'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t               r_state,      w_state_nxt;
    logic [c_ptr_w-1:0]   r_rr_ptr,     w_rr_ptr_nxt;
    logic [c_ptr_w-1:0]   r_grant_id,   w_grant_id_nxt;
    logic [NUM_REQ-1:0]   r_req_ready,  w_req_ready_nxt;
    logic [NUM_REQ-1:0]   r_resp_valid, w_resp_valid_nxt;
    logic                 r_resp_err,   w_resp_err_nxt;
    logic [c_bcd_w-1:0]   r_resp_bcd,   w_resp_bcd_nxt;
    logic [INPUT_WIDTH-1:0] r_dd_binary, w_dd_binary_nxt;
    logic                 r_dd_start,   w_dd_start_nxt;
    logic [c_cnt_w-1:0]   r_cnt,        w_cnt_nxt;

    logic [c_ptr_w-1:0]     w_pick_idx;
    logic                   w_any_valid;
    logic [INPUT_WIDTH-1:0] w_pick_operand;
    logic [c_ptr_w-1:0]     w_rr_after_grant;

    dd_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_ptr_w)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant_idx (w_pick_idx),
        .any_valid (w_any_valid)
    );

    assign w_pick_operand =
        req_binary[operand_lsb(int'(w_pick_idx), INPUT_WIDTH) +: INPUT_WIDTH];

    assign w_rr_after_grant = (r_grant_id == c_ptr_w'(NUM_REQ - 1)) ?
                              '0 : r_grant_id + 1'b1;

    always_comb begin
        w_state_nxt      = r_state;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_grant_id_nxt   = r_grant_id;
        w_req_ready_nxt  = '0;
        w_resp_valid_nxt = '0;
        w_resp_err_nxt   = 1'b0;
        w_resp_bcd_nxt   = r_resp_bcd;
        w_dd_binary_nxt  = r_dd_binary;
        w_dd_start_nxt   = 1'b0;
        w_cnt_nxt        = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_req_ready_nxt[w_pick_idx] = 1'b1;
                    w_dd_binary_nxt = w_pick_operand;
                    w_dd_start_nxt  = 1'b1;
                    w_grant_id_nxt  = w_pick_idx;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A done level still present from a previous job is not ours.
                if (dd_done && !r_dd_start) begin
                    w_resp_bcd_nxt               = dd_bcd;
                    w_resp_valid_nxt[r_grant_id] = 1'b1;
                    w_rr_ptr_nxt                 = w_rr_after_grant;
                    w_state_nxt                  = ST_IDLE;
                end else if (c_to_en && (r_cnt == c_to_last)) begin
                    w_resp_bcd_nxt               = '0;
                    w_resp_valid_nxt[r_grant_id] = 1'b1;
                    w_resp_err_nxt               = 1'b1;
                    w_rr_ptr_nxt                 = w_rr_after_grant;
                    w_state_nxt                  = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            r_resp_err   <= 1'b0;
            r_resp_bcd   <= '0;
            r_dd_binary  <= '0;
            r_dd_start   <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_resp_bcd   <= w_resp_bcd_nxt;
            r_dd_binary  <= w_dd_binary_nxt;
            r_dd_start   <= w_dd_start_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_bcd   = r_resp_bcd;
    assign dd_binary  = r_dd_binary;
    assign dd_start   = r_dd_start;
    assign busy       = (r_state == ST_BUSY);
    assign grant_id   = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_dd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dd_arbiter
//  Description : Directed self-checking bench for dd_arbiter (two instances:
//                long watchdog with converter model, short watchdog).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dd_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct {
        int          id;
        logic [31:0] bin;
        int          cyc;
    } grant_rec_t;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] bcd;
        logic        err;
        int          cyc;
    } resp_rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: default watchdog, converter modelled below
    logic           resetn = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_binary = '0;
    logic [N-1:0]   req_ready, resp_valid;
    logic [31:0]    resp_bcd, dd_binary;
    logic           resp_err, dd_start, busy;
    logic [31:0]    dd_bcd = '0;
    logic           dd_done = 1'b0;
    logic [1:0]     grant_id;

    // Instance B: 16-cycle watchdog, converter driven by hand
    logic           resetn_t = 1'b0;
    logic [N-1:0]   req_valid_t;
    logic [N*W-1:0] req_binary_t = '0;
    logic [N-1:0]   req_ready_t, resp_valid_t;
    logic [31:0]    resp_bcd_t, dd_binary_t;
    logic           resp_err_t, dd_start_t, busy_t;
    logic [31:0]    dd_bcd_t = '0;
    logic           dd_done_t = 1'b0;
    logic [1:0]     grant_id_t;

    dd_arbiter #(.NUM_REQ(N), .INPUT_WIDTH(W), .DECIMAL_DIGITS(8), .TIMEOUT_CYCLES(1024)) u_dut_a (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_binary(req_binary),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_bcd(resp_bcd), .resp_err(resp_err),
        .dd_binary(dd_binary), .dd_start(dd_start), .dd_bcd(dd_bcd), .dd_done(dd_done),
        .busy(busy), .grant_id(grant_id)
    );

    dd_arbiter #(.NUM_REQ(N), .INPUT_WIDTH(W), .DECIMAL_DIGITS(8), .TIMEOUT_CYCLES(16)) u_dut_b (
        .clk(clk), .resetn(resetn_t), .req_valid(req_valid_t), .req_binary(req_binary_t),
        .req_ready(req_ready_t), .resp_valid(resp_valid_t), .resp_bcd(resp_bcd_t), .resp_err(resp_err_t),
        .dd_binary(dd_binary_t), .dd_start(dd_start_t), .dd_bcd(dd_bcd_t), .dd_done(dd_done_t),
        .busy(busy_t), .grant_id(grant_id_t)
    );

    // A requester is pending while it has posted more requests than were accepted.
    int post_a [N] = '{default: 0};
    int serve_a[N] = '{default: 0};
    int post_b [N] = '{default: 0};
    int serve_b[N] = '{default: 0};

    always_comb begin
        req_valid   = '0;
        req_valid_t = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]   = (post_a[i] != serve_a[i]);
            req_valid_t[i] = (post_b[i] != serve_b[i]);
        end
    end

    grant_rec_t ga_q[$];
    grant_rec_t gb_q[$];
    resp_rec_t  ra_q[$];
    resp_rec_t  rb_q[$];
    int         busy_a_cnt = 0;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                ga_q.push_back('{id: i, bin: dd_binary, cyc: cyc});
                serve_a[i] = serve_a[i] + 1;
            end
            if (req_ready_t[i]) begin
                gb_q.push_back('{id: i, bin: dd_binary_t, cyc: cyc});
                serve_b[i] = serve_b[i] + 1;
            end
        end
        if (resp_valid != '0)
            ra_q.push_back('{mask: resp_valid, bcd: resp_bcd, err: resp_err, cyc: cyc});
        if (resp_valid_t != '0)
            rb_q.push_back('{mask: resp_valid_t, bcd: resp_bcd_t, err: resp_err_t, cyc: cyc});
        if (busy)
            busy_a_cnt = busy_a_cnt + 1;
    end

    function automatic logic [31:0] to_bcd(input logic [31:0] b);
        logic [31:0] r;
        longint      v;
        r = '0;
        v = longint'(b);
        for (int d = 0; d < 8; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Converter model for instance A: done is sampled lat_a edges after the grant.
    int          lat_a   = 34;
    bit          early_a = 1'b0;
    int          rem_a   = 0;
    logic [31:0] pend_a  = '0;

    always @(negedge clk) begin
        if (dd_start) begin
            rem_a   = lat_a - 1;
            pend_a  = dd_binary;
            dd_done = early_a;
            dd_bcd  = early_a ? 32'hBADBAD00 : 32'h0;
        end else if (rem_a > 0) begin
            rem_a   = rem_a - 1;
            dd_done = (rem_a == 0);
            dd_bcd  = (rem_a == 0) ? to_bcd(pend_a) : 32'h0;
        end else begin
            dd_done = 1'b0;
            dd_bcd  = 32'h0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int sel);
        case (sel)
            0:       return ga_q.size();
            1:       return ra_q.size();
            2:       return gb_q.size();
            default: return rb_q.size();
        endcase
    endfunction

    task automatic wait_q(input int sel, input int n, input int bound, input string tag);
        int k;
        k = 0;
        while (qsize(sel) < n && k < bound) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        check(tag, 64'(qsize(sel) >= n), 64'd1);
    endtask

    task automatic post_a_req(input int i, input logic [31:0] v);
        req_binary[i*W +: W] = v;
        post_a[i] = post_a[i] + 1;
    endtask

    task automatic post_b_req(input int i, input logic [31:0] v);
        req_binary_t[i*W +: W] = v;
        post_b[i] = post_b[i] + 1;
    endtask

    logic [31:0] exp2 [4] = '{32'h1, 32'h22, 32'h333, 32'h4444};
    int g0, r0, b0, t0;

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // ---- reset values
        repeat (3) @(negedge clk);
        check("rst_ctrl_a", {busy, resp_valid, req_ready, dd_start, resp_err, grant_id}, 64'd0);
        check("rst_data_a", {resp_bcd, dd_binary}, 64'd0);
        check("rst_ctrl_b", {busy_t, resp_valid_t, req_ready_t, dd_start_t, resp_err_t, grant_id_t}, 64'd0);
        resetn   = 1'b1;
        resetn_t = 1'b1;
        @(negedge clk);

        // ---- single request, 34-cycle converter
        g0 = ga_q.size(); r0 = ra_q.size(); b0 = busy_a_cnt;
        lat_a = 34;
        post_a_req(1, 32'h000004D2);
        wait_q(1, r0 + 1, 100, "t1_resp_seen");
        repeat (2) @(negedge clk);
        check("t1_ready_count", ga_q.size() - g0, 1);
        check("t1_grant", ga_q[g0].id, 1);
        check("t1_dd_binary", ga_q[g0].bin, 32'h000004D2);
        check("t1_resp", {ra_q[r0].mask, ra_q[r0].err, ra_q[r0].bcd}, {4'b0010, 1'b0, 32'h00001234});
        check("t1_busy_cycles", busy_a_cnt - b0, 34);
        check("t1_latency", ra_q[r0].cyc - ga_q[g0].cyc, 34);

        // ---- all four from reset
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        g0 = ga_q.size(); r0 = ra_q.size();
        lat_a = 5;
        post_a_req(0, 32'd1);
        post_a_req(1, 32'd22);
        post_a_req(2, 32'd333);
        post_a_req(3, 32'd4444);
        wait_q(1, r0 + 4, 200, "t2_resp_seen");
        repeat (3) @(negedge clk);
        check("t2_ready_count", ga_q.size() - g0, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_grant%0d", i), ga_q[g0+i].id, i);
            check($sformatf("t2_resp%0d", i), {ra_q[r0+i].mask, ra_q[r0+i].err, ra_q[r0+i].bcd},
                  {4'b0001 << i, 1'b0, exp2[i]});
        end

        // ---- pointer: after 1 completes, 2 beats 0
        g0 = ga_q.size(); r0 = ra_q.size();
        post_a_req(1, 32'd5);
        wait_q(1, r0 + 1, 100, "t3_first_resp");
        post_a_req(0, 32'd10);
        post_a_req(2, 32'd20);
        wait_q(1, r0 + 3, 200, "t3_resp_seen");
        check("t3_grant_second", ga_q[g0+1].id, 2);
        check("t3_grant_third", ga_q[g0+2].id, 0);
        check("t3_resp_second", {ra_q[r0+1].mask, ra_q[r0+1].bcd}, {4'b0100, 32'h20});
        check("t3_resp_third", {ra_q[r0+2].mask, ra_q[r0+2].bcd}, {4'b0001, 32'h10});

        // ---- max operand, done held during the start cycle
        g0 = ga_q.size(); r0 = ra_q.size();
        lat_a = 8; early_a = 1'b1;
        post_a_req(2, 32'h05F5E0FF);
        wait_q(1, r0 + 1, 100, "t4_resp_seen");
        early_a = 1'b0;
        check("t4_resp", {ra_q[r0].mask, ra_q[r0].err, ra_q[r0].bcd}, {4'b0100, 1'b0, 32'h99999999});
        check("t4_latency", ra_q[r0].cyc - ga_q[g0].cyc, 8);
        check("t4_grant_id_held", grant_id, 2);

        // ---- reset mid-conversion
        g0 = ga_q.size(); r0 = ra_q.size();
        lat_a = 20;
        post_a_req(3, 32'd55);
        wait_q(0, g0 + 1, 50, "t5_grant_seen");
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("t5_rst_ctrl", {busy, resp_valid, req_ready, dd_start, resp_err, grant_id}, 64'd0);
        check("t5_rst_data", {resp_bcd, dd_binary}, 64'd0);
        resetn = 1'b1;
        repeat (30) @(negedge clk);
        check("t5_no_resp", ra_q.size() - r0, 0);
        lat_a = 5;
        post_a_req(0, 32'd66);
        post_a_req(3, 32'd77);
        wait_q(1, r0 + 2, 200, "t5_resp_seen");
        check("t5_grant_after_rst", ga_q[g0+1].id, 0);
        check("t5_grant_next", ga_q[g0+2].id, 3);
        check("t5_resp_first", {ra_q[r0].mask, ra_q[r0].bcd}, {4'b0001, 32'h66});

        // ---- watchdog (instance B, converter silent)
        g0 = gb_q.size(); r0 = rb_q.size();
        post_b_req(0, 32'd7);
        post_b_req(2, 32'd9);
        wait_q(3, r0 + 1, 100, "tb_timeout_seen");
        check("tb_timeout_resp", {rb_q[r0].mask, rb_q[r0].err, rb_q[r0].bcd}, {4'b0001, 1'b1, 32'h0});
        check("tb_timeout_latency", rb_q[r0].cyc - gb_q[g0].cyc, 16);
        wait_q(2, g0 + 2, 20, "tb_next_grant_seen");
        check("tb_next_grant", gb_q[g0+1].id, 2);
        check("tb_next_operand", gb_q[g0+1].bin, 32'd9);
        t0 = gb_q[g0+1].cyc;
        while (cyc < t0 + 3) @(negedge clk);
        dd_done_t = 1'b1; dd_bcd_t = 32'h9;
        @(negedge clk);
        dd_done_t = 1'b0; dd_bcd_t = 32'h0;
        wait_q(3, r0 + 2, 50, "tb_normal_seen");
        check("tb_normal_resp", {rb_q[r0+1].mask, rb_q[r0+1].err, rb_q[r0+1].bcd}, {4'b0100, 1'b0, 32'h9});
        check("tb_normal_latency", rb_q[r0+1].cyc - t0, 4);

        // ---- done on the timeout cycle wins
        post_b_req(1, 32'd5);
        wait_q(2, g0 + 3, 20, "tb_edge_grant_seen");
        t0 = gb_q[g0+2].cyc;
        while (cyc < t0 + 15) @(negedge clk);
        dd_done_t = 1'b1; dd_bcd_t = 32'h5;
        @(negedge clk);
        dd_done_t = 1'b0; dd_bcd_t = 32'h0;
        wait_q(3, r0 + 3, 50, "tb_edge_seen");
        check("tb_edge_resp", {rb_q[r0+2].mask, rb_q[r0+2].err, rb_q[r0+2].bcd}, {4'b0010, 1'b0, 32'h5});
        check("tb_edge_latency", rb_q[r0+2].cyc - t0, 16);
        repeat (2) @(negedge clk);
        check("tb_final_state", {busy_t, grant_id_t}, {1'b0, 2'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
